// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset core: ready/valid instruction fetch, owned register file, retire port.
// Define CPU_RETIRE_COUNTER_EN to add the 64-bit instret retire counter output.
module cpu_multicycle #(
  parameter int              XLEN      = 32,
  parameter int              REG_COUNT = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            retire_valid,
  output logic [XLEN-1:0] retire_pc,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            halted,
  output logic            illegal
`ifdef CPU_RETIRE_COUNTER_EN
  ,
  output logic [63:0]     instret
`endif
);

  localparam int         SHW       = $clog2(XLEN);
  localparam int         RIW       = $clog2(REG_COUNT);
  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXECUTE,
    WRITEBACK,
    HALT
  } state_e;

  state_e          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [31:0]     instr_reg;
  logic            halt_after_reg;
  logic [XLEN-1:0] regs [REG_COUNT];

  logic [6:0]      opcode;
  logic [4:0]      rd_idx;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] pc_next;
  logic            shift_ok;
  logic            op_ok;
  logic            use_rs1;
  logic            use_rs2;
  logic            use_rd;
  logic            is_sys;
  logic            legal;
  logic            wb_we;

  function automatic logic idx_bad(input logic [4:0] idx);
    return {1'b0, idx} >= REG_LIMIT;
  endfunction

  assign opcode  = instr_reg[6:0];
  assign rd_idx  = instr_reg[11:7];
  assign funct3  = instr_reg[14:12];
  assign rs1_idx = instr_reg[19:15];
  assign rs2_idx = instr_reg[24:20];
  assign funct7  = instr_reg[31:25];

  assign rs1_val = (rs1_idx == 5'd0) ? '0 : regs[rs1_idx[RIW-1:0]];
  assign rs2_val = (rs2_idx == 5'd0) ? '0 : regs[rs2_idx[RIW-1:0]];
  assign imm_i   = XLEN'($signed(instr_reg[31:20]));
  assign imm_u   = XLEN'($signed({instr_reg[31:12], 12'h000}));
  assign op_b    = (opcode == OPC_OP) ? rs2_val : imm_i;
  assign shamt   = op_b[SHW-1:0];
  assign pc_next = pc_reg + XLEN'(4);
  assign wb_we   = (state_reg == WRITEBACK) && (retire_rd != 5'd0);

  // Shift immediates: upper funct bits must be clear except bit 30 (SRAI); bit 25 is shamt[5] only for XLEN=64.
  assign shift_ok = !instr_reg[31] && (instr_reg[29:26] == 4'd0) && ((XLEN == 64) || !instr_reg[25]);

  always_comb begin
    alu_res = '0;
    if (opcode == OPC_LUI) begin
      alu_res = imm_u;
    end else begin
      case (funct3)
        3'd0:    alu_res = (opcode == OPC_OP && funct7[5]) ? rs1_val - op_b : rs1_val + op_b;
        3'd1:    alu_res = rs1_val << shamt;
        3'd2:    alu_res[0] = $signed(rs1_val) < $signed(op_b);
        3'd3:    alu_res[0] = rs1_val < op_b;
        3'd4:    alu_res = rs1_val ^ op_b;
        3'd5:    alu_res = funct7[5] ? XLEN'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
        3'd6:    alu_res = rs1_val | op_b;
        default: alu_res = rs1_val & op_b;
      endcase
    end
  end

  always_comb begin
    op_ok   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    is_sys  = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        op_ok   = (funct7 == 7'd0) || (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5));
      end
      OPC_IMM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        if (funct3 == 3'd1)      op_ok = shift_ok && !instr_reg[30];
        else if (funct3 == 3'd5) op_ok = shift_ok;
        else                     op_ok = 1'b1;
      end
      OPC_LUI: begin
        use_rd = 1'b1;
        op_ok  = 1'b1;
      end
      OPC_SYS: begin
        // Only ECALL (imm 0) and EBREAK (imm 1) with rd/rs1/funct3 all zero.
        is_sys = (instr_reg[31:21] == 11'd0) && (instr_reg[19:7] == 13'd0);
        op_ok  = is_sys;
      end
      default: op_ok = 1'b0;
    endcase
    legal = op_ok && !(use_rd && idx_bad(rd_idx)) && !(use_rs1 && idx_bad(rs1_idx))
            && !(use_rs2 && idx_bad(rs2_idx));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[retire_rd[RIW-1:0]] <= retire_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= FETCH_REQ;
      pc_reg         <= RESET_PC;
      instr_reg      <= '0;
      halt_after_reg <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      retire_valid   <= 1'b0;
      retire_pc      <= '0;
      retire_rd      <= '0;
      retire_data    <= '0;
      halted         <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      case (state_reg)
        FETCH_REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state_reg      <= FETCH_WAIT;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            instr_reg <= imem_rsp_data;
            state_reg <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (!legal) begin
            state_reg     <= HALT;
            halted        <= 1'b1;
            illegal       <= 1'b1;
            imem_req_addr <= '0;
          end else begin
            // retire_data doubles as the result register written back to rd.
            state_reg      <= WRITEBACK;
            retire_valid   <= 1'b1;
            retire_pc      <= pc_reg;
            retire_rd      <= rd_idx;
            retire_data    <= (rd_idx == 5'd0) ? '0 : alu_res;
            halt_after_reg <= is_sys;
          end
        end
        WRITEBACK: begin
          retire_valid <= 1'b0;
          retire_pc    <= '0;
          retire_rd    <= '0;
          retire_data  <= '0;
          pc_reg       <= pc_next;
          if (halt_after_reg) begin
            state_reg     <= HALT;
            halted        <= 1'b1;
            imem_req_addr <= '0;
          end else begin
            state_reg      <= FETCH_REQ;
            imem_req_valid <= 1'b1;
            imem_req_addr  <= pc_next;
          end
        end
        HALT: ;
        default: state_reg <= HALT;
      endcase
    end
  end

`ifdef CPU_RETIRE_COUNTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) instret <= '0;
    else if (state_reg == WRITEBACK) instret <= instret + 64'd1;
  end
`endif

endmodule
